alu_arbiter: RTL

Two-port round-robin arbiter that shares one `alu` instance between two requesters, such as a fetch/branch unit and an execute unit. Each port issues operations over a valid/ready request channel and receives registered results over a valid/ready response channel. The block sits between the requesters and the shared ALU datapath. It sequences one operation at a time through a two-state FSM and counts completed operations.

---
 rtl/alu_types.sv | 25 ++
 rtl/alu.sv | 59 +++++
 rtl/alu_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_types.sv
// Shared ALU operation encoding and arbiter state type.
package alu_types;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_NOR  = 4'd3,
        ALU_ADD  = 4'd4,
        ALU_SUB  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10
    } alu_control_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } alu_arb_state_t;

    localparam int unsigned NumPorts = 2;

endpackage

// File: rtl/alu.sv
// Combinational ALU: logic, add/sub with signed overflow, set-less-than and shifts.
module alu
    import alu_types::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  alu_control_t control_i,
    output logic [N-1:0] result_o,
    output logic         overflow_o,
    output logic         zero_o,
    output logic         equal_o
);

    localparam int unsigned ShW = $clog2(N);

    logic [N-1:0]   sum;
    logic [N-1:0]   diff;
    logic [ShW-1:0] shamt;
    logic           lt_signed;
    logic           lt_unsigned;

    assign sum         = a_i + b_i;
    assign diff        = a_i - b_i;
    assign shamt       = b_i[ShW-1:0];
    assign lt_signed   = $signed(a_i) < $signed(b_i);
    assign lt_unsigned = a_i < b_i;

    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        case (control_i)
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_ADD: begin
                result_o   = sum;
                // Same-sign operands producing an opposite-sign sum.
                overflow_o = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
            end
            ALU_SUB: begin
                result_o   = diff;
                overflow_o = (a_i[N-1] != b_i[N-1]) && (diff[N-1] != a_i[N-1]);
            end
            ALU_SLT:  result_o = {{(N-1){1'b0}}, lt_signed};
            ALU_SLTU: result_o = {{(N-1){1'b0}}, lt_unsigned};
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $signed(a_i) >>> shamt;
            default:  result_o = '0;
        endcase
    end

    assign zero_o  = (result_o == '0);
    assign equal_o = (a_i == b_i);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end sharing one ALU; registered per-port response slots.
module alu_arbiter
    import alu_types::*;
#(
    parameter int unsigned N  = 32,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req_valid_0,
    output logic          req_ready_0,
    input  logic [N-1:0]  req_a_0,
    input  logic [N-1:0]  req_b_0,
    input  alu_control_t  req_control_0,
    output logic          rsp_valid_0,
    input  logic          rsp_ready_0,
    output logic [N-1:0]  rsp_result_0,
    output logic          rsp_overflow_0,
    output logic          rsp_zero_0,
    output logic          rsp_equal_0,

    input  logic          req_valid_1,
    output logic          req_ready_1,
    input  logic [N-1:0]  req_a_1,
    input  logic [N-1:0]  req_b_1,
    input  alu_control_t  req_control_1,
    output logic          rsp_valid_1,
    input  logic          rsp_ready_1,
    output logic [N-1:0]  rsp_result_1,
    output logic          rsp_overflow_1,
    output logic          rsp_zero_1,
    output logic          rsp_equal_1,

    output logic [CW-1:0] ops_done
);

    alu_arb_state_t state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           owner_q, owner_d;
    logic [N-1:0]   op_a_q, op_a_d;
    logic [N-1:0]   op_b_q, op_b_d;
    alu_control_t   op_ctrl_q, op_ctrl_d;
    logic [CW-1:0]  ops_done_q, ops_done_d;

    logic [NumPorts-1:0] rsp_valid_q, rsp_valid_d;
    logic [N-1:0]        rsp_result_q   [NumPorts];
    logic [N-1:0]        rsp_result_d   [NumPorts];
    logic                rsp_overflow_q [NumPorts];
    logic                rsp_overflow_d [NumPorts];
    logic                rsp_zero_q     [NumPorts];
    logic                rsp_zero_d     [NumPorts];
    logic                rsp_equal_q    [NumPorts];
    logic                rsp_equal_d    [NumPorts];

    logic [NumPorts-1:0] eligible;
    logic [NumPorts-1:0] grant;
    logic [NumPorts-1:0] rsp_ready;

    logic [N-1:0] alu_result;
    logic         alu_overflow;
    logic         alu_zero;
    logic         alu_equal;

    alu #(
        .N (N)
    ) u_alu (
        .a_i        (op_a_q),
        .b_i        (op_b_q),
        .control_i  (op_ctrl_q),
        .result_o   (alu_result),
        .overflow_o (alu_overflow),
        .zero_o     (alu_zero),
        .equal_o    (alu_equal)
    );

    // A port whose slot is still full (even if draining now) must wait.
    assign eligible  = {req_valid_1 & ~rsp_valid_q[1], req_valid_0 & ~rsp_valid_q[0]};
    assign rsp_ready = {rsp_ready_1, rsp_ready_0};

    always_comb begin
        grant = '0;
        if ((state_q == S_IDLE) && !rst) begin
            if (eligible == 2'b11) begin
                grant = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                grant = eligible;
            end
        end
    end

    assign req_ready_0 = grant[0];
    assign req_ready_1 = grant[1];

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        owner_d        = owner_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        op_ctrl_d      = op_ctrl_q;
        ops_done_d     = ops_done_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_result_d   = rsp_result_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_equal_d    = rsp_equal_q;

        for (int p = 0; p < NumPorts; p++) begin
            if (rsp_valid_q[p] && rsp_ready[p]) begin
                rsp_valid_d[p] = 1'b0;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (grant != '0) begin
                    owner_d   = grant[1];
                    op_a_d    = grant[1] ? req_a_1       : req_a_0;
                    op_b_d    = grant[1] ? req_b_1       : req_b_0;
                    op_ctrl_d = grant[1] ? req_control_1 : req_control_0;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_valid_d[owner_q]    = 1'b1;
                rsp_result_d[owner_q]   = alu_result;
                rsp_overflow_d[owner_q] = alu_overflow;
                rsp_zero_d[owner_q]     = alu_zero;
                rsp_equal_d[owner_q]    = alu_equal;
                last_grant_d            = owner_q;
                ops_done_d              = ops_done_q + CW'(1);
                state_d                 = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_ctrl_q    <= ALU_AND;
            ops_done_q   <= '0;
            rsp_valid_q  <= '0;
            for (int p = 0; p < NumPorts; p++) begin
                rsp_result_q[p]   <= '0;
                rsp_overflow_q[p] <= 1'b0;
                rsp_zero_q[p]     <= 1'b0;
                rsp_equal_q[p]    <= 1'b0;
            end
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            owner_q        <= owner_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            op_ctrl_q      <= op_ctrl_d;
            ops_done_q     <= ops_done_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_equal_q    <= rsp_equal_d;
        end
    end

    assign rsp_valid_0    = rsp_valid_q[0];
    assign rsp_result_0   = rsp_result_q[0];
    assign rsp_overflow_0 = rsp_overflow_q[0];
    assign rsp_zero_0     = rsp_zero_q[0];
    assign rsp_equal_0    = rsp_equal_q[0];

    assign rsp_valid_1    = rsp_valid_q[1];
    assign rsp_result_1   = rsp_result_q[1];
    assign rsp_overflow_1 = rsp_overflow_q[1];
    assign rsp_zero_1     = rsp_zero_q[1];
    assign rsp_equal_1    = rsp_equal_q[1];

    assign ops_done = ops_done_q;

endmodule
